// File: rtl/wb_stage.sv
// wb_stage: writeback merge of in-order pipeline results and a buffered long-latency FIFO.
// Define WB_LOAD_EXT_EN to enable byte/halfword load selection and extension.
module wb_stage #(
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_valid,
    input  logic [4:0]       p_rd,
    input  logic [31:0]      p_alu,
    input  logic             p_is_load,
    input  logic [31:0]      p_ld_data,
    input  logic [1:0]       p_ld_size,
    input  logic             p_ld_sign,
    input  logic [1:0]       p_ld_off,
    input  logic             lu_valid,
    output logic             lu_ready,
    input  logic [4:0]       lu_rd,
    input  logic [31:0]      lu_data,
    output logic             we,
    output logic [4:0]       w_addr,
    output logic [31:0]      w_data,
    output logic [PTR_W:0]   fifo_cnt
);
    localparam int DEPTH = 1 << PTR_W;
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
    logic [4:0]       q_rd   [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_live;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [31:0]      ld_res, p_res;
    logic             p_wr, push, pop, head_live;
`ifdef WB_LOAD_EXT_EN
    logic [7:0]       ld_b;
    logic [15:0]      ld_h;
    always_comb begin
        ld_b   = p_ld_data[{p_ld_off, 3'b000} +: 8];
        ld_h   = p_ld_data[{p_ld_off[1], 4'b0000} +: 16];
        ld_res = p_ld_size == 2'b00 ? {{24{p_ld_sign & ld_b[7]}}, ld_b} :
                 p_ld_size == 2'b01 ? {{16{p_ld_sign & ld_h[15]}}, ld_h} : p_ld_data;
    end
`else
    logic unused_ld;
    assign unused_ld = ^{p_ld_size, p_ld_sign, p_ld_off};
    assign ld_res = p_ld_data;
`endif
    assign p_res     = p_is_load ? ld_res : p_alu;
    assign lu_ready  = !rst && fifo_cnt != FULL;
    assign p_wr      = p_valid && p_rd != 5'd0;
    assign push      = lu_valid && lu_ready && lu_rd != 5'd0;
    assign pop       = !p_wr && fifo_cnt != '0;
    assign head_live = q_live[rd_ptr];
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= lu_rd;
            q_data[wr_ptr] <= lu_data;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we       <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
            fifo_cnt <= '0;
            q_live   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            // a pipeline write is younger than every buffered result to the same rd
            for (int i = 0; i < DEPTH; i++)
                if (p_wr && q_rd[i] == p_rd) q_live[i] <= 1'b0;
            if (push) begin
                q_live[wr_ptr] <= !(p_wr && lu_rd == p_rd);
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            we       <= p_wr || (pop && head_live);
            if (p_wr) begin
                w_addr <= p_rd;
                w_data <= p_res;
            end else if (pop && head_live) begin
                w_addr <= q_rd[rd_ptr];
                w_data <= q_data[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vector table plus hand sequences for wb_stage (default PTR_W=2).
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p_valid = 1'b0, p_is_load = 1'b0, p_ld_sign = 1'b0, lu_valid = 1'b0;
    logic [4:0]  p_rd = '0, lu_rd = '0;
    logic [31:0] p_alu = '0, p_ld_data = 32'h80FF_7F01, lu_data = '0;
    logic [1:0]  p_ld_size = '0, p_ld_off = '0;
    logic        lu_ready, we;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [2:0]  fifo_cnt;
    int n_chk = 0, n_bad = 0;

    wb_stage dut (
        .clk(clk), .rst(rst), .p_valid(p_valid), .p_rd(p_rd), .p_alu(p_alu),
        .p_is_load(p_is_load), .p_ld_data(p_ld_data), .p_ld_size(p_ld_size),
        .p_ld_sign(p_ld_sign), .p_ld_off(p_ld_off), .lu_valid(lu_valid),
        .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data), .we(we),
        .w_addr(w_addr), .w_data(w_data), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

`ifdef WB_LOAD_EXT_EN
    localparam logic [31:0] E_B3S  = 32'hFFFF_FF80;
    localparam logic [31:0] E_H2U  = 32'h0000_80FF;
    localparam logic [31:0] E_B0U  = 32'h0000_0001;
    localparam logic [31:0] E_H3S  = 32'hFFFF_80FF;
`else
    localparam logic [31:0] E_B3S  = 32'h80FF_7F01;
    localparam logic [31:0] E_H2U  = 32'h80FF_7F01;
    localparam logic [31:0] E_B0U  = 32'h80FF_7F01;
    localparam logic [31:0] E_H3S  = 32'h80FF_7F01;
`endif

    typedef struct {
        logic pv; logic [4:0] prd; logic [31:0] alu; logic ld;
        logic [1:0] sz; logic sg; logic [1:0] off;
        logic lv; logic [4:0] lrd; logic [31:0] ldat;
        logic ewe; logic [4:0] eaddr; logic [31:0] edata; logic [2:0] ecnt;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic e_we, input logic [4:0] e_addr,
                           input logic [31:0] e_data, input logic [2:0] e_cnt);
        chk({name, ".we"}, 32'(we), 32'(e_we));
        chk({name, ".w_addr"}, 32'(w_addr), 32'(e_addr));
        chk({name, ".w_data"}, w_data, e_data);
        chk({name, ".fifo_cnt"}, 32'(fifo_cnt), 32'(e_cnt));
    endtask

    task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] alu,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        p_valid = pv; p_rd = prd; p_alu = alu; p_is_load = 1'b0;
        lu_valid = lv; lu_rd = lrd; lu_data = ldat;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0] = '{1'b1, 5'd5, 32'h0000_1234, 1'b0, 2'b10, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h0000_1234, 3'd0};
        vt[1] = '{1'b1, 5'd0, 32'h0000_DEAD, 1'b0, 2'b10, 1'b0, 2'd0, 1'b1, 5'd0, 32'h0000_BEEF, 1'b0, 5'd5, 32'h0000_1234, 3'd0};
        vt[2] = '{1'b0, 5'd0, 32'h0, 1'b0, 2'b10, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 32'h0000_1234, 3'd0};
        vt[3] = '{1'b1, 5'd3, 32'h0, 1'b1, 2'b00, 1'b1, 2'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, E_B3S, 3'd0};
        vt[4] = '{1'b1, 5'd4, 32'h0, 1'b1, 2'b01, 1'b0, 2'd2, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, E_H2U, 3'd0};
        vt[5] = '{1'b1, 5'd6, 32'h0, 1'b1, 2'b11, 1'b1, 2'd1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h80FF_7F01, 3'd0};
        vt[6] = '{1'b1, 5'd8, 32'h0, 1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8, E_B0U, 3'd0};
        vt[7] = '{1'b1, 5'd31, 32'h0, 1'b1, 2'b01, 1'b1, 2'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31, E_H3S, 3'd0};

        // power-on reset
        step; step;
        chk_out("por", 1'b0, 5'd0, 32'h0, 3'd0);
        chk("por.lu_ready", 32'(lu_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("por_rel.lu_ready", 32'(lu_ready), 32'd1);

        foreach (vt[k]) begin
            p_valid = vt[k].pv; p_rd = vt[k].prd; p_alu = vt[k].alu; p_is_load = vt[k].ld;
            p_ld_size = vt[k].sz; p_ld_sign = vt[k].sg; p_ld_off = vt[k].off;
            lu_valid = vt[k].lv; lu_rd = vt[k].lrd; lu_data = vt[k].ldat;
            step;
            chk_out($sformatf("vec%0d", k), vt[k].ewe, vt[k].eaddr, vt[k].edata, vt[k].ecnt);
        end

        // lu latency, and pipeline rd=0 lets the FIFO pop
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
        step; chk_out("lu_push", 1'b0, 5'd31, E_H3S, 3'd1);
        drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
        step; chk_out("lu_pop_r0", 1'b1, 5'd9, 32'h99, 3'd0);

        // fill while pipeline writes rd=1, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd1, 32'h100 + 32'(i), 1'b1, 5'(2 + i), 32'h20 + 32'(i));
            step; chk_out($sformatf("fill%0d", i), 1'b1, 5'd1, 32'h100 + 32'(i), 3'(i + 1));
        end
        chk("full.lu_ready", 32'(lu_ready), 32'd0);
        drive(1'b1, 5'd1, 32'h1FF, 1'b1, 5'd10, 32'h10);
        step; chk_out("full_hold", 1'b1, 5'd1, 32'h1FF, 3'd4);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'h11);
        step; chk_out("drain0", 1'b1, 5'd2, 32'h20, 3'd3);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int i = 1; i < 4; i++) begin
            step; chk_out($sformatf("drain%0d", i), 1'b1, 5'(2 + i), 32'h20 + 32'(i), 3'(3 - i));
        end
        step; chk_out("drain_empty", 1'b0, 5'd5, 32'h23, 3'd0);

        // WAW kill of a buffered entry
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hAA);
        step; chk_out("waw_q", 1'b0, 5'd5, 32'h23, 3'd1);
        drive(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'h0);
        step; chk_out("waw_p", 1'b1, 5'd7, 32'hBB, 3'd1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step; chk_out("waw_kill", 1'b0, 5'd7, 32'hBB, 3'd0);

        // same-cycle collision: lu entry pushed already killed
        drive(1'b1, 5'd12, 32'hCC, 1'b1, 5'd12, 32'hDD);
        step; chk_out("waw_same", 1'b1, 5'd12, 32'hCC, 3'd1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step; chk_out("waw_same_pop", 1'b0, 5'd12, 32'hCC, 3'd0);

        // simultaneous push and pop keeps the count
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'h13);
        step; chk_out("pp0", 1'b0, 5'd12, 32'hCC, 3'd1);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h14);
        step; chk_out("pp1", 1'b1, 5'd13, 32'h13, 3'd1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step; chk_out("pp2", 1'b1, 5'd14, 32'h14, 3'd0);

        // async reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd1, 32'h55, 1'b1, 5'(20 + i), 32'h77);
            step;
        end
        chk_out("pre_rst", 1'b1, 5'd1, 32'h55, 3'd3);
        #2 rst = 1'b1;
        #1 chk_out("async_rst", 1'b0, 5'd0, 32'h0, 3'd0);
        chk("async_rst.lu_ready", 32'(lu_ready), 32'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_rel.lu_ready", 32'(lu_ready), 32'd1);
        step; chk_out("post_rst", 1'b0, 5'd0, 32'h0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
